// File: rtl/usb_pkt_decoder_pkg.sv
// Shared types for the USB receive-side packet decoder: PID encodings,
// token field record, CRC5 constants, decoder states and a CRC5 helper.
package usb_pkt_decoder_pkg;

    typedef enum logic [3:0] {
        PID_RESERVED = 4'b0000,
        PID_OUT      = 4'b0001,
        PID_ACK      = 4'b0010,
        PID_DATA0    = 4'b0011,
        PID_PING     = 4'b0100,
        PID_SOF      = 4'b0101,
        PID_NYET     = 4'b0110,
        PID_DATA2    = 4'b0111,
        PID_SPLIT    = 4'b1000,
        PID_IN       = 4'b1001,
        PID_NAK      = 4'b1010,
        PID_DATA1    = 4'b1011,
        PID_PRE_ERR  = 4'b1100,
        PID_SETUP    = 4'b1101,
        PID_STALL    = 4'b1110,
        PID_MDATA    = 4'b1111
    } pid_t;

    typedef struct packed {
        pid_t       pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [4:0] crc5;
    } tok_rec_t;

    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
    localparam logic [4:0] CRC5_POLY     = 5'b00101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOK1,
        S_TOK2,
        S_TEND,
        S_HS,
        S_DATA,
        S_DISCARD
    } dec_state_t;

    // Advance the CRC5 register over one byte, LSB first (wire order).
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        logic       fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ data[i];
            c  = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_pkt_decoder_if.sv
// Byte stream from the receiver into the decoder plus the decoded results
// going out to the SIE. master = receiver/SIE side, slave = decoder.
interface usb_pkt_decoder_if;
    import usb_pkt_decoder_pkg::*;

    logic        rx_active;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_error;

    logic        tok_valid;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        sof_valid;
    logic [10:0] frame_no;
    logic        hs_valid;
    logic        data_start;
    logic [3:0]  data_pid;
    logic        data_valid;
    logic [7:0]  data_out;
    logic        data_end;
    logic        pid_err;
    logic        crc5_err;
    logic        len_err;
    logic        endp_err;

    modport master (
        output rx_active, rx_valid, rx_data, rx_error,
        input  tok_valid, tok_pid, tok_addr, tok_endp, sof_valid, frame_no,
               hs_valid, data_start, data_pid, data_valid, data_out, data_end,
               pid_err, crc5_err, len_err, endp_err
    );

    modport slave (
        input  rx_active, rx_valid, rx_data, rx_error,
        output tok_valid, tok_pid, tok_addr, tok_endp, sof_valid, frame_no,
               hs_valid, data_start, data_pid, data_valid, data_out, data_end,
               pid_err, crc5_err, len_err, endp_err
    );
endinterface

// File: rtl/usb_crc5.sv
// Byte-wide USB CRC5 accumulator. Feed every byte after the PID; the
// residual flag is valid once the CRC byte itself has been absorbed.
module usb_crc5
    import usb_pkt_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [7:0] i_data,
    output logic       o_residual_ok
);
    logic [4:0] r_crc;

    // CRC register: preset on reset/clear, otherwise absorb one byte per enable.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_crc <= CRC5_INIT;
        end else if (i_enable) begin
            r_crc <= crc5_byte(r_crc, i_data);
        end
    end

    assign o_residual_ok = (r_crc == CRC5_RESIDUAL);
endmodule

// File: rtl/usb_pkt_decoder.sv
// Receive-side USB packet decoder: PID classification, token/SOF decode
// with CRC5 and address/endpoint filtering, handshake and data streaming.
module usb_pkt_decoder
    import usb_pkt_decoder_pkg::*;
#(
    parameter int NUM_ENDP     = 4,
    parameter bit SOF_ANY_ADDR = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         dev_addr,
    usb_pkt_decoder_if.slave   bus
);
    dec_state_t  r_state, w_state_next;
    pid_t        r_cur_pid;
    logic [6:0]  r_cur_addr;
    logic [3:0]  r_cur_endp;

    logic        r_tok_valid, r_sof_valid, r_hs_valid, r_data_start, r_data_valid, r_data_end;
    logic        r_pid_err, r_crc5_err, r_len_err, r_endp_err;
    logic [3:0]  r_tok_pid, r_tok_endp, r_data_pid;
    logic [6:0]  r_tok_addr;
    logic [10:0] r_frame_no;
    logic [7:0]  r_data_out;

    logic        w_tok_valid, w_sof_valid, w_hs_valid, w_data_start, w_data_valid, w_data_end;
    logic        w_pid_err, w_crc5_err, w_len_err, w_endp_err;
    logic [3:0]  w_tok_pid, w_tok_endp, w_data_pid;
    logic [6:0]  w_tok_addr;
    logic [10:0] w_frame_no;
    logic [7:0]  w_data_out;
    logic        w_cap_pid, w_cap_b1, w_cap_b2, w_crc_clear, w_crc_en;

    logic        w_byte, w_chk_ok, w_crc_ok, w_addr_match, w_endp_ok;
    pid_t        w_pid;

    // A byte only counts while the packet is active.
    assign w_byte       = bus.rx_active & bus.rx_valid;
    assign w_pid        = pid_t'(bus.rx_data[3:0]);
    assign w_chk_ok     = (bus.rx_data[7:4] == ~bus.rx_data[3:0]);
    assign w_addr_match = (r_cur_addr == dev_addr);
    assign w_endp_ok    = ({28'd0, r_cur_endp} < NUM_ENDP);

    usb_crc5 u_crc5 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_crc_clear),
        .i_enable      (w_crc_en),
        .i_data        (bus.rx_data),
        .o_residual_ok (w_crc_ok)
    );

    // State, captured packet fields and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_DISCARD;
            r_cur_pid    <= PID_RESERVED;
            r_cur_addr   <= '0;
            r_cur_endp   <= '0;
            r_tok_valid  <= 1'b0; r_sof_valid <= 1'b0; r_hs_valid <= 1'b0;
            r_data_start <= 1'b0; r_data_valid <= 1'b0; r_data_end <= 1'b0;
            r_pid_err    <= 1'b0; r_crc5_err <= 1'b0; r_len_err <= 1'b0; r_endp_err <= 1'b0;
            r_tok_pid    <= '0; r_tok_addr <= '0; r_tok_endp <= '0;
            r_frame_no   <= '0; r_data_pid <= '0; r_data_out <= '0;
        end else begin
            r_state      <= w_state_next;
            if (w_cap_pid) r_cur_pid <= w_pid;
            if (w_cap_b1) begin
                r_cur_addr    <= bus.rx_data[6:0];
                r_cur_endp[0] <= bus.rx_data[7];
            end
            if (w_cap_b2) r_cur_endp[3:1] <= bus.rx_data[2:0];
            r_tok_valid  <= w_tok_valid;  r_sof_valid  <= w_sof_valid;  r_hs_valid <= w_hs_valid;
            r_data_start <= w_data_start; r_data_valid <= w_data_valid; r_data_end <= w_data_end;
            r_pid_err    <= w_pid_err;    r_crc5_err   <= w_crc5_err;
            r_len_err    <= w_len_err;    r_endp_err   <= w_endp_err;
            r_tok_pid    <= w_tok_pid;    r_tok_addr   <= w_tok_addr;   r_tok_endp <= w_tok_endp;
            r_frame_no   <= w_frame_no;   r_data_pid   <= w_data_pid;   r_data_out <= w_data_out;
        end
    end

    // Next state, pulse decisions and field updates; rx_error always wins.
    always_comb begin
        w_state_next = r_state;
        w_tok_valid = 1'b0; w_sof_valid = 1'b0; w_hs_valid = 1'b0;
        w_data_start = 1'b0; w_data_valid = 1'b0; w_data_end = 1'b0;
        w_pid_err = 1'b0; w_crc5_err = 1'b0; w_len_err = 1'b0; w_endp_err = 1'b0;
        w_tok_pid = r_tok_pid; w_tok_addr = r_tok_addr; w_tok_endp = r_tok_endp;
        w_frame_no = r_frame_no; w_data_pid = r_data_pid; w_data_out = r_data_out;
        w_cap_pid = 1'b0; w_cap_b1 = 1'b0; w_cap_b2 = 1'b0;
        w_crc_clear = 1'b0; w_crc_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_active && bus.rx_error) begin
                    w_state_next = S_DISCARD;
                end else if (w_byte) begin
                    w_crc_clear = 1'b1;
                    w_cap_pid   = 1'b1;
                    if (!w_chk_ok) begin
                        w_pid_err    = 1'b1;
                        w_state_next = S_DISCARD;
                    end else begin
                        case (w_pid)
                            PID_OUT, PID_IN, PID_SETUP, PID_SOF:      w_state_next = S_TOK1;
                            PID_ACK, PID_NAK, PID_STALL, PID_NYET:    w_state_next = S_HS;
                            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: begin
                                w_data_start = 1'b1;
                                w_data_pid   = w_pid;
                                w_state_next = S_DATA;
                            end
                            default: begin
                                w_pid_err    = 1'b1;
                                w_state_next = S_DISCARD;
                            end
                        endcase
                    end
                end
            end
            S_TOK1, S_TOK2: begin
                if (bus.rx_error) begin
                    w_state_next = S_DISCARD;
                end else if (w_byte) begin
                    w_crc_en     = 1'b1;
                    w_cap_b1     = (r_state == S_TOK1);
                    w_cap_b2     = (r_state == S_TOK2);
                    w_state_next = (r_state == S_TOK1) ? S_TOK2 : S_TEND;
                end else if (!bus.rx_active) begin
                    w_len_err    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_TEND: begin
                if (bus.rx_error) begin
                    w_state_next = S_DISCARD;
                end else if (w_byte) begin
                    w_len_err    = 1'b1;
                    w_state_next = S_DISCARD;
                end else if (!bus.rx_active) begin
                    w_state_next = S_IDLE;
                    if (!w_crc_ok) begin
                        w_crc5_err = 1'b1;
                    end else if (r_cur_pid == PID_SOF) begin
                        if (SOF_ANY_ADDR || w_addr_match) begin
                            w_sof_valid = 1'b1;
                            w_frame_no  = {r_cur_endp, r_cur_addr};
                        end
                    end else if (!w_addr_match) begin
                        w_state_next = S_IDLE;
                    end else if (!w_endp_ok) begin
                        w_endp_err = 1'b1;
                    end else begin
                        w_tok_valid = 1'b1;
                        w_tok_pid   = r_cur_pid;
                        w_tok_addr  = r_cur_addr;
                        w_tok_endp  = r_cur_endp;
                    end
                end
            end
            S_HS: begin
                if (bus.rx_error) begin
                    w_state_next = S_DISCARD;
                end else if (w_byte) begin
                    w_len_err    = 1'b1;
                    w_state_next = S_DISCARD;
                end else if (!bus.rx_active) begin
                    w_hs_valid   = 1'b1;
                    w_tok_pid    = r_cur_pid;
                    w_state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (bus.rx_error) begin
                    w_data_end   = 1'b1;
                    w_state_next = S_DISCARD;
                end else if (w_byte) begin
                    w_data_valid = 1'b1;
                    w_data_out   = bus.rx_data;
                end else if (!bus.rx_active) begin
                    w_data_end   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (!bus.rx_active) w_state_next = S_IDLE;
            end
            default: w_state_next = S_DISCARD;
        endcase
    end

    assign bus.tok_valid  = r_tok_valid;
    assign bus.tok_pid    = r_tok_pid;
    assign bus.tok_addr   = r_tok_addr;
    assign bus.tok_endp   = r_tok_endp;
    assign bus.sof_valid  = r_sof_valid;
    assign bus.frame_no   = r_frame_no;
    assign bus.hs_valid   = r_hs_valid;
    assign bus.data_start = r_data_start;
    assign bus.data_pid   = r_data_pid;
    assign bus.data_valid = r_data_valid;
    assign bus.data_out   = r_data_out;
    assign bus.data_end   = r_data_end;
    assign bus.pid_err    = r_pid_err;
    assign bus.crc5_err   = r_crc5_err;
    assign bus.len_err    = r_len_err;
    assign bus.endp_err   = r_endp_err;
endmodule

// File: tb/tb_usb_pkt_decoder.sv
// Directed bench for usb_pkt_decoder: expected output events are queued as
// each packet is driven and matched by a monitor as the DUT produces them.
module tb_usb_pkt_decoder;
    localparam int K_TOK = 1, K_SOF = 2, K_HS = 3, K_DSTART = 4, K_DV = 5;
    localparam int K_DEND = 6, K_PID = 7, K_CRC = 8, K_LEN = 9, K_ENDP = 10;

    typedef struct {
        int          kind;
        logic [31:0] a;
    } ev_t;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    int         total = 0;
    int         bad = 0;
    ev_t        exp_q[$];

    usb_pkt_decoder_if bus();

    usb_pkt_decoder #(.NUM_ENDP(4), .SOF_ANY_ADDR(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dev_addr (dev_addr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tokv(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
        return {17'd0, pid, addr, endp};
    endfunction

    // Bytes 1 and 2 of a token/SOF carrying 11-bit field d, with the
    // transmitted CRC5 (inverted remainder, MSB first on the wire).
    function automatic byte_q_t tok_bytes(input logic [7:0] pid_byte, input logic [10:0] d);
        logic [4:0] r;
        logic [4:0] c;
        logic       fb;
        byte_q_t    q;
        r = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = r[4] ^ d[i];
            r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        c = ~r;
        q.push_back(pid_byte);
        q.push_back(d[7:0]);
        q.push_back({c[0], c[1], c[2], c[3], c[4], d[10:8]});
        return q;
    endfunction

    task automatic expect_ev(input int kind, input logic [31:0] a);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input string tag);
        ev_t e;
        e.kind = 0;
        e.a    = 32'd0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        total++;
        assert (kind === e.kind && a === e.a) else begin
            bad++;
            $error("FAIL %s: observed kind=%0d val=%h expected kind=%0d val=%h", tag, kind, a, e.kind, e.a);
        end
        $display("event %s kind=%0d val=%h", tag, kind, a);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every output pulse is an event to be matched in order.
    always @(negedge clk) begin
        if (bus.tok_valid  === 1'b1) observe(K_TOK, tokv(bus.tok_pid, bus.tok_addr, bus.tok_endp), "tok_valid");
        if (bus.sof_valid  === 1'b1) observe(K_SOF, {21'd0, bus.frame_no}, "sof_valid");
        if (bus.hs_valid   === 1'b1) observe(K_HS, {28'd0, bus.tok_pid}, "hs_valid");
        if (bus.data_start === 1'b1) observe(K_DSTART, {28'd0, bus.data_pid}, "data_start");
        if (bus.data_valid === 1'b1) observe(K_DV, {24'd0, bus.data_out}, "data_valid");
        if (bus.data_end   === 1'b1) observe(K_DEND, 32'd0, "data_end");
        if (bus.pid_err    === 1'b1) observe(K_PID, 32'd0, "pid_err");
        if (bus.crc5_err   === 1'b1) observe(K_CRC, tokv(bus.tok_pid, bus.tok_addr, bus.tok_endp), "crc5_err");
        if (bus.len_err    === 1'b1) observe(K_LEN, 32'd0, "len_err");
        if (bus.endp_err   === 1'b1) observe(K_ENDP, tokv(bus.tok_pid, bus.tok_addr, bus.tok_endp), "endp_err");
    end

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_active = 1'b1;
        bus.rx_valid  = 1'b1;
        bus.rx_data   = b;
    endtask

    task automatic eop();
        @(negedge clk);
        bus.rx_valid  = 1'b0;
        bus.rx_active = 1'b0;
    endtask

    task automatic send(input byte_q_t q);
        foreach (q[i]) put_byte(q[i]);
        eop();
    endtask

    // Wait (bounded) for all expected events, then confirm nothing is left.
    task automatic drain(input string tag);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++;
        assert (exp_q.size() === 0) else begin
            bad++;
            $error("FAIL %s: pending events observed %0d expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_active = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_error  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pulses", {22'd0, bus.tok_valid, bus.sof_valid, bus.hs_valid, bus.data_start,
            bus.data_valid, bus.data_end, bus.pid_err, bus.crc5_err, bus.len_err, bus.endp_err}, 32'd0);
        chk("reset_tok_fields", tokv(bus.tok_pid, bus.tok_addr, bus.tok_endp), 32'd0);
        chk("reset_frame_no", {21'd0, bus.frame_no}, 32'd0);
        chk("reset_data_fields", {20'd0, bus.data_pid, bus.data_out}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // SETUP addr 0 endp 0, with exact-latency check on tok_valid
        dev_addr = 7'd0;
        expect_ev(K_TOK, tokv(4'hD, 7'd0, 4'd0));
        put_byte(8'h2D); put_byte(8'h00); put_byte(8'h10);
        eop();
        @(negedge clk);
        chk("setup_latency", {31'd0, bus.tok_valid}, 32'd1);
        drain("setup");

        // Corrupted CRC: error pulse, reported token fields unchanged
        expect_ev(K_CRC, tokv(4'hD, 7'd0, 4'd0));
        send('{8'h2D, 8'h00, 8'h11});
        drain("crc_bad");

        // SOF for frame 0 at foreign address, then frame 0x7FF
        dev_addr = 7'd7;
        expect_ev(K_SOF, 32'h000);
        send('{8'hA5, 8'h00, 8'h10});
        drain("sof_0");
        expect_ev(K_SOF, 32'h7FF);
        send(tok_bytes(8'hA5, 11'h7FF));
        drain("sof_7ff");

        // Handshakes: ACK ok, ACK with extra byte, bad check nibble
        expect_ev(K_HS, 32'h2);
        send('{8'hD2});
        drain("ack");
        expect_ev(K_LEN, 32'd0);
        send('{8'hD2, 8'h55});
        drain("ack_long");
        expect_ev(K_PID, 32'd0);
        send('{8'hD3});
        drain("pid_bad");

        // DATA0 with five payload bytes; data_start latency checked directly
        expect_ev(K_DSTART, 32'h3);
        expect_ev(K_DV, 32'h01); expect_ev(K_DV, 32'h02); expect_ev(K_DV, 32'h03);
        expect_ev(K_DV, 32'hE5); expect_ev(K_DV, 32'hF6);
        expect_ev(K_DEND, 32'd0);
        put_byte(8'hC3);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("dstart_latency", {28'd0, bus.data_start, 3'd0}, 32'h8);
        put_byte(8'h01); put_byte(8'h02); put_byte(8'h03); put_byte(8'hE5); put_byte(8'hF6);
        eop();
        drain("data0");

        // DATA1 aborted by rx_error mid-payload
        expect_ev(K_DSTART, 32'hB);
        expect_ev(K_DV, 32'h11); expect_ev(K_DV, 32'h22);
        expect_ev(K_DEND, 32'd0);
        put_byte(8'h4B); put_byte(8'h11); put_byte(8'h22);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b1;
        @(negedge clk);
        bus.rx_error = 1'b0;
        put_byte(8'h33);
        eop();
        drain("data_err");

        // IN to endpoint 5: rejected when addressed to us, silent otherwise
        dev_addr = 7'd0;
        expect_ev(K_ENDP, tokv(4'h2, 7'd0, 4'd0));
        send(tok_bytes(8'h69, {4'd5, 7'd0}));
        drain("endp_bad");
        dev_addr = 7'd3;
        send(tok_bytes(8'h69, {4'd5, 7'd0}));
        drain("addr_miss");

        // Reset in mid-packet: no pulse for that packet
        dev_addr = 7'd0;
        put_byte(8'h2D); put_byte(8'h00);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        put_byte(8'h10);
        eop();
        drain("reset_mid");

        // Next packet decodes normally: OUT addr 0 endp 3
        expect_ev(K_TOK, tokv(4'h1, 7'd0, 4'd3));
        send(tok_bytes(8'hE1, {4'd3, 7'd0}));
        drain("out_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usb_pkt_decoder.md
Name: usb_pkt_decoder

Overview:
- Receive-side packet decoder between the byte-level receiver (NRZI-decoded, bit-unstuffed, SYNC-stripped) and the SIE control logic.
- Classifies each packet by PID, validates the PID check nibble, and decodes token fields (address, endpoint, CRC5).
- Extracts SOF frame numbers and streams data-packet payload bytes onward.
- Successor to the fixed token record: generalised endpoint count, address filtering, SOF/data/handshake handling and error reporting.

Parameters:
- NUM_ENDP, 4, number of implemented endpoints (1..16); tokens addressed to an endpoint >= NUM_ENDP are rejected.
- SOF_ANY_ADDR, 1, 1: SOF is reported regardless of dev_addr (per USB); 0: SOF is subject to address filtering like other tokens.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst_n  in  1  synchronous, active-low reset.
- dev_addr  in  7  assigned device address, sampled when a token completes.
- rx_active  in  1  high from the first PID byte until EOP.
- rx_valid  in  1  strobe: rx_data holds one received byte.
- rx_data  in  8  received byte, LSB = first bit on the wire.
- rx_error  in  1  bit-stuff/line error from the receiver; the packet is corrupt.
- tok_valid  out  1  one-cycle pulse: valid token (OUT/IN/SETUP) for this device.
- tok_pid  out  4  PID of the last reported token or handshake.
- tok_addr  out  7  token address.
- tok_endp  out  4  token endpoint.
- sof_valid  out  1  one-cycle pulse: valid SOF received.
- frame_no  out  11  frame number of the last valid SOF.
- hs_valid  out  1  one-cycle pulse: handshake PID (ACK/NAK/STALL/NYET) received in a 1-byte packet.
- data_start  out  1  one-cycle pulse: DATA0/1/2/MDATA PID accepted; data_pid is valid.
- data_pid  out  4  data PID.
- data_valid  out  1  payload byte strobe (includes the 2 CRC16 bytes, unchecked).
- data_out  out  8  payload byte.
- data_end  out  1  one-cycle pulse at EOP of a data packet.
- pid_err  out  1  one-cycle pulse: PID check nibble mismatch, or a reserved/unsupported PID.
- crc5_err  out  1  one-cycle pulse: token/SOF CRC5 residual wrong.
- len_err  out  1  one-cycle pulse: token not exactly 3 bytes, or handshake not exactly 1 byte.
- endp_err  out  1  one-cycle pulse: address matched but endp >= NUM_ENDP.

Behaviour:
- Reset: all pulse outputs 0; tok_pid, tok_addr, tok_endp, frame_no, data_pid, data_out = 0; state = S_DISCARD.
- Byte format: PID byte is {~pid, pid}, bits 7:4 must equal the inverse of bits 3:0.
- Token byte 1: addr = bits 6:0, endp[0] = bit 7.
- Token byte 2: endp[3:1] = bits 2:0, crc5 = bits 7:3.
- CRC5: polynomial x^5+x^2+1, register initialised to 5'b11111, all 16 bits after the PID shifted LSB-first; valid iff the final residual == 5'b01100.
- rx_valid while rx_active = 0 is ignored.
- States:
  - S_IDLE: on rx_active & rx_valid, decode the PID.
    - Check nibble bad, or PID one of SPLIT/PING/PRE_ERR/RESERVED -> pid_err, go to S_DISCARD.
    - Token/SOF -> S_TOK1.
    - Handshake -> S_HS.
    - Data -> data_start, go to S_DATA.
  - S_TOK1: byte -> S_TOK2.
  - S_TOK2: byte -> S_TEND.
  - S_TEND: if rx_active falls with no further byte, evaluate the token (below). An extra byte -> len_err, go to S_DISCARD.
  - S_HS: if rx_active falls -> hs_valid. A byte arrives -> len_err, go to S_DISCARD.
  - S_DATA: each byte -> data_valid/data_out in the next cycle. rx_active falls -> data_end, go to S_IDLE.
  - S_DISCARD: wait for rx_active = 0, then go to S_IDLE. No outputs are produced.
- rx_active falling in S_TOK1/S_TOK2 -> len_err, go to S_IDLE.
- rx_error in any non-idle state -> go to S_DISCARD; no success pulse for that packet. In S_DATA, data_end is still pulsed so downstream frees its buffer.
- Token evaluation happens in the cycle after rx_active is sampled low, in this order:
  1. CRC bad -> crc5_err.
  2. Otherwise, SOF (and SOF_ANY_ADDR=1 or address matches) -> sof_valid, frame_no = {byte2[2:0], byte1}.
  3. Otherwise, addr != dev_addr -> silently dropped, no pulse.
  4. Otherwise, endp >= NUM_ENDP -> endp_err.
  5. Otherwise -> tok_valid, with tok_pid/tok_addr/tok_endp updated in the same cycle.
- Latency:
  - Success/error pulses appear exactly 1 cycle after the deciding input (PID byte, or rx_active low).
  - data_out appears 1 cycle after its rx_valid.
- Each output field holds its value until the next successful update.
- Back-to-back packets: rx_active may rise in the cycle after EOP is sampled; S_IDLE is entered in time, so no packet is lost.
- Reset mid-packet: enter S_DISCARD; the rest of that packet is ignored.

Decomposition:
- Shared types package:
  - pid_t with the 16 USB PID encodings.
  - Token field record {pid, addr, endp, crc5}.
  - Constant for CRC5 init 5'b11111.
  - Constant for CRC5 residual 5'b01100.
  - Decoder state enum.
- Sub-module usb_crc5: byte-wide CRC5 update (clear, enable, byte in, residual_ok out), reused later by the transmitter.

Test Plan:
- dev_addr=0: bytes 2D 00 10 (SETUP, addr 0, endp 0, valid CRC) -> one tok_valid, tok_pid=4'b1101, tok_addr=0, tok_endp=0, no error pulses.
- Bytes 2D 00 11 -> crc5_err pulse only; tok_pid/tok_addr/tok_endp unchanged.
- SOF A5 00 10 with dev_addr=7, SOF_ANY_ADDR=1 -> sof_valid, frame_no=0. Then bench-CRC'd SOF for frame 0x7FF -> frame_no=11'h7FF.
- Bytes D2 (ACK), then EOP -> hs_valid, tok_pid=4'b0010. Bytes D2 55 -> len_err, no hs_valid. Byte D3 (bad check nibble) -> pid_err.
- Bytes C3 01 02 03 E5 F6 (DATA0) -> data_start with data_pid=4'b0011, five data_valid pulses carrying 01 02 03 E5 F6 in order, data_end after EOP. rx_error asserted mid-payload -> data_end, no further data_valid.
- Bench-CRC'd IN token to addr 0, endp 5, NUM_ENDP=4 -> endp_err. Same token to addr 3 -> no pulse at all. Reset asserted after byte 1 -> no pulse; the next packet decodes normally.
